// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the round-robin arbiter and the FIFO write port.
// The slave modport is the arbiter; master is the producer/FIFO environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [GRANT_W-1:0]            grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts of up to MAX_BURST.
// Optional per-requester completed-burst counters: define FIFO_WR_ARB_GRANT_CNT_EN.
//
// state   | meaning
// IDLE    | no owner; pick next valid requester from rr_ptr
// BURST   | owner streams beats to the FIFO until MAX_BURST or valid drops
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0] burst_cnt
`endif
);

  localparam int GRANT_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic               sel_found;
  logic [GRANT_W-1:0] sel_idx;
  logic               in_burst, owner_valid, beat, last_beat, burst_end;

  // Wrap is explicit so non-power-of-2 NUM_REQ never selects a phantom index.
  always_comb begin : rr_select
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = GRANT_W'(cand);
      end
    end
  end

  assign in_burst    = (state_q == S_BURST);
  assign owner_valid = bus.req_valid[owner_q];
  assign beat        = in_burst & owner_valid & ~bus.fifo_full;
  assign last_beat   = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign burst_end   = in_burst & (~owner_valid | (beat & last_beat));

  always_comb begin : ready_decode
    bus.req_ready = '0;
    if (in_burst && !bus.fifo_full) bus.req_ready[owner_q] = 1'b1;
  end

  assign bus.fifo_wr_en = beat;
  assign bus.fifo_din   = in_burst ? bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH]
                                   : '0;
  assign bus.grant_id   = owner_q;
  assign bus.busy       = in_burst;

  always_comb begin : next_state
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == S_IDLE) begin
      if (sel_found) begin
        state_d    = S_BURST;
        owner_d    = sel_idx;
        beat_cnt_d = '0;
      end
    end else begin
      if (burst_end) begin
        state_d    = S_IDLE;
        rr_ptr_d   = (owner_q == GRANT_W'(NUM_REQ - 1)) ? '0 : owner_q + GRANT_W'(1);
        beat_cnt_d = '0;
      end else if (beat) begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_GRANT_CNT_EN
  logic [15:0] bcnt_q [NUM_REQ];
  logic [15:0] bcnt_d [NUM_REQ];

  // Saturating so a long-running owner never wraps back to a small count.
  always_comb begin : bcnt_next
    bcnt_d = bcnt_q;
    if (burst_end && (bcnt_q[owner_q] != 16'hFFFF))
      bcnt_d[owner_q] = bcnt_q[owner_q] + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) bcnt_q[i] <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bcnt
    assign burst_cnt[g*16 +: 16] = bcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model built on per-producer data queues.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
  logic [N*16-1:0] burst_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    ,
    .burst_cnt (burst_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: producer data queues, current grant, beats taken, next start pointer.
  logic [DW-1:0] q [N][$];
  bit  m_busy;
  int  m_owner, m_cnt, m_ptr;
  int  m_bursts [N];
  bit  stall_prev;
  int  stall_left;
  bit  stall_arm;
  bit  rand_gap, rand_full;
  int  grant_log [$];
  int  log_id [$];
  logic [DW-1:0] log_data [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int writes_from(input int id);
    int c = 0;
    foreach (log_id[k]) if (log_id[k] == id) c++;
    return c;
  endfunction

  // Called at posedge+1 (or before the first edge): asserts rst mid-cycle and checks async effect.
  task automatic apply_reset(input logic [N-1:0] vmask);
    rst = 1'b0;
    bus.req_valid = vmask;
    bus.fifo_full = 1'b0;
    #1;
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_din", bus.fifo_din, 0);
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    chk("rst_burst_cnt", burst_cnt, 0);
`endif
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_bursts[i] = 0;
    stall_prev = 0; stall_left = 0; stall_arm = 0;
    grant_log.delete(); log_id.delete(); log_data.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
  endtask

  task automatic step();
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [N-1:0]    exp_ready;
    logic            f;
    int              o;
    bit              found, beat;
    if (stall_arm && m_busy && m_owner == 1 && m_cnt == 1) begin
      stall_left = 5;
      stall_arm  = 0;
    end
    f = 1'b0;
    if (stall_left > 0) begin
      f = 1'b1;
      stall_left--;
    end else if (rand_full) begin
      f = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < N; i++) begin
      v[i] = (q[i].size() > 0) && (!rand_gap || $urandom_range(0, 3) != 0);
      d[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : DW'($urandom);
    end
    if (m_busy && stall_prev) v[m_owner] = 1'b1;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.fifo_full = f;
    @(negedge clk);
    o = m_owner;
    if (!m_busy) begin
      chk("idle_ready", bus.req_ready, 0);
      chk("idle_wr_en", bus.fifo_wr_en, 0);
      chk("idle_din", bus.fifo_din, 0);
      chk("idle_busy", bus.busy, 0);
    end else begin
      exp_ready = '0;
      if (!f) exp_ready[o] = 1'b1;
      chk("burst_ready", bus.req_ready, exp_ready);
      chk("burst_wr_en", bus.fifo_wr_en, v[o] && !f);
      chk("burst_din", bus.fifo_din, d[o*DW +: DW]);
      chk("burst_grant", bus.grant_id, o);
      chk("burst_busy", bus.busy, 1);
    end
    if (bus.fifo_wr_en === 1'b1) begin
      log_id.push_back(int'(bus.grant_id));
      log_data.push_back(bus.fifo_din);
    end
    stall_prev = m_busy && f && v[o];
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && v[c]) begin
          found = 1;
          m_owner = c;
        end
      end
      if (found) begin
        m_busy = 1;
        m_cnt  = 0;
        grant_log.push_back(m_owner);
      end
    end else begin
      beat = v[o] && !f;
      if (beat) begin
        void'(q[o].pop_front());
        m_cnt++;
      end
      if (!v[o] || m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (o + 1) % N;
        m_bursts[o]++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int max_cycles);
    int k = 0;
    while ((!queues_empty() || m_busy) && k < max_cycles) begin
      step();
      k++;
    end
    chk("drain_in_budget", (queues_empty() && !m_busy), 1);
  endtask

  initial begin
    int k;
    int len [N];
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    rand_gap = 0; rand_full = 0;
    #1;
    apply_reset('0);

    // Mid-stream reset while requester 1 owns the port; first grant afterwards must be 0.
    clear_queues();
    for (int i = 0; i < N; i++) for (int j = 0; j < 6; j++) q[i].push_back(DW'($urandom));
    k = 0;
    while (!(m_busy && m_owner == 1 && m_cnt >= 1) && k < 60) begin
      step();
      k++;
    end
    chk("reach_owner1", (m_busy && m_owner == 1), 1);
    apply_reset(4'hF);
    run(300);
    chk("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Single requester 2, six beats: burst of 4, one idle gap, burst of 2.
    clear_queues();
    apply_reset('0);
    for (int j = 0; j < 6; j++) q[2].push_back(DW'(8'h11 + j));
    run(100);
    chk("single_n_writes", log_data.size(), 6);
    for (int j = 0; j < 6 && j < log_data.size(); j++) begin
      chk("single_data", log_data[j], 8'h11 + j);
      chk("single_id", log_id[j], 2);
    end
    chk("single_n_grants", grant_log.size(), 2);

    // Round-robin with everyone valid: 0,1,2,3,0.
    clear_queues();
    apply_reset('0);
    for (int i = 0; i < N; i++) for (int j = 0; j < ((i == 0) ? 8 : 4); j++)
      q[i].push_back(DW'(i*16 + j));
    run(200);
    chk("rr_n_grants", grant_log.size(), 5);
    for (int j = 0; j < 5 && j < grant_log.size(); j++) chk("rr_grant_order", grant_log[j], j % N);
    for (int i = 0; i < N; i++) chk("rr_writes", writes_from(i), (i == 0) ? 8 : 4);
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
    chk("rr_bcnt0", burst_cnt[0*16 +: 16], 2);
    chk("rr_bcnt1", burst_cnt[1*16 +: 16], 1);
    chk("rr_bcnt2", burst_cnt[2*16 +: 16], 1);
    chk("rr_bcnt3", burst_cnt[3*16 +: 16], 1);
`endif

    // Five-cycle full stall on owner 1's second beat.
    clear_queues();
    apply_reset('0);
    for (int j = 0; j < 4; j++) q[1].push_back(DW'(8'hA0 + j));
    stall_arm = 1;
    run(100);
    chk("stall_fired", stall_arm, 0);
    chk("stall_n_writes", log_data.size(), 4);
    for (int j = 0; j < 4 && j < log_data.size(); j++) begin
      chk("stall_data", log_data[j], 8'hA0 + j);
      chk("stall_id", log_id[j], 1);
    end
    chk("stall_n_grants", grant_log.size(), 1);

    // Early release: requester 3 drops after 2 beats, pointer moves to 0.
    clear_queues();
    apply_reset('0);
    q[2].push_back(8'h5A);
    run(50);
    q[3].push_back(8'h31); q[3].push_back(8'h32);
    for (int j = 0; j < 3; j++) q[0].push_back(DW'(8'h01 + j));
    run(100);
    chk("early_n_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("early_g1", grant_log[1], 3);
      chk("early_g2", grant_log[2], 0);
    end
    chk("early_writes3", writes_from(3), 2);
    chk("early_writes0", writes_from(0), 3);

    // Randomized traffic with valid gaps and random full.
    for (int r = 0; r < 4; r++) begin
      clear_queues();
      apply_reset('0);
      rand_gap = 1; rand_full = 1;
      for (int i = 0; i < N; i++) begin
        len[i] = $urandom_range(0, 12);
        for (int j = 0; j < len[i]; j++) q[i].push_back(DW'($urandom));
      end
      run(2000);
      for (int i = 0; i < N; i++) chk("rand_writes", writes_from(i), len[i]);
`ifdef FIFO_WR_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) chk("rand_bcnt", burst_cnt[i*16 +: 16], m_bursts[i]);
`endif
      rand_gap = 0; rand_full = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
